// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, FSM states,
// and the lane-enable / alignment helpers used by the request decode.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // Big-endian lanes: bit 3 of the enable is bits [31:24], i.e. byte offset 0.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: byte_enable = 4'b1000 >> offset;
            SIZE_HALF: byte_enable = offset[1] ? 4'b0011 : 4'b1100;
            SIZE_WORD: byte_enable = 4'b1111;
            default:   byte_enable = 4'b0000;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = !offset[0];
            SIZE_WORD: is_aligned = (offset == 2'b00);
            default:   is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_pipe.sv
// Fixed-depth delay line for responses; only the pipeline contents are reset,
// so a reset drops every response still in flight.
module dmem_resp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_err,
    input  logic [31:0] in_rdata,
    output logic        out_valid,
    output logic        out_err,
    output logic [31:0] out_rdata
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        rdata_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            rdata_q[0] <= in_rdata;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_rdata = rdata_q[LATENCY-1];

endmodule

// File: rtl/dmem_bytelane.sv
// MEM-stage data memory with big-endian byte/half/word access, a post-reset
// clear walk, sticky error capture and a fixed-latency response pipe.
module dmem_bytelane #(
    parameter int          ADDR_WIDTH     = 14,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF0000,
    parameter int          READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] err_addr,
    output logic        err_seen
);
    import dmem_pkg::*;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] clr_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_idx <= '0;
        end else begin
            state <= next_state;
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == ST_CLEAR && (&clr_idx)) next_state = ST_READY;
    end

    assign req_ready = (state == ST_READY);

    // Word-granular subtract with a borrow bit: addresses below BASE_ADDR set
    // word_off[30] instead of wrapping into the array.
    logic [30:0]           word_off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  req_err;
    logic                  accept;
    logic                  wr_en;
    logic [3:0]            be;

    assign word_off = {1'b0, req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign in_range = !word_off[30] && ((word_off[29:0] >> ADDR_WIDTH) == 30'd0);
    assign idx      = word_off[ADDR_WIDTH-1:0];
    assign req_err  = !in_range || !is_aligned(req_size, req_addr[1:0]);
    assign accept   = req_valid && req_ready && rst_n;
    assign wr_en    = accept && req_write && !req_err;
    assign be       = byte_enable(req_size, req_addr[1:0]);

    logic [31:0] mem [DEPTH];
    logic [31:0] wdata_lanes;

    always_comb begin
        wdata_lanes = req_wdata;
        case (req_size)
            SIZE_BYTE: wdata_lanes = {4{req_wdata[7:0]}};
            SIZE_HALF: wdata_lanes = {2{req_wdata[15:0]}};
            default:   wdata_lanes = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    // Read happens at accept, before this edge's write, so the pipe only delays it.
    logic [31:0] rd_word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;

    assign rd_word  = mem[idx];
    assign byte_val = 8'(rd_word >> {~req_addr[1:0], 3'b000});
    assign half_val = req_addr[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_data = '0;
        if (accept && !req_write && !req_err) begin
            case (req_size)
                SIZE_BYTE: load_data = {{24{req_signed & byte_val[7]}}, byte_val};
                SIZE_HALF: load_data = {{16{req_signed & half_val[15]}}, half_val};
                default:   load_data = rd_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_seen <= 1'b0;
            err_addr <= '0;
        end else if (accept && req_err && !err_seen) begin
            err_seen <= 1'b1;
            err_addr <= req_addr;
        end
    end

    dmem_resp_pipe #(
        .LATENCY(READ_LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (accept),
        .in_err   (accept && req_err),
        .in_rdata (load_data),
        .out_valid(resp_valid),
        .out_err  (resp_err),
        .out_rdata(resp_rdata)
    );

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench: dut_a is a small cleared array at latency 1, dut_b is a full
// uncleared array at latency 3 for forwarding, top-address and reset tests.
module tb_dmem_bytelane;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rv    [2];
    logic        rw    [2];
    logic        rsg   [2];
    logic [1:0]  rsz   [2];
    logic [31:0] ra    [2];
    logic [31:0] rwd   [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic        rerr  [2];
    logic [31:0] rdat  [2];
    logic [31:0] eaddr [2];
    logic        eseen [2];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_bytelane #(
        .ADDR_WIDTH(4), .BASE_ADDR(32'hFFFF0000), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_write(rw[0]), .req_size(rsz[0]), .req_signed(rsg[0]), .req_addr(ra[0]),
        .req_wdata(rwd[0]), .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0]),
        .err_addr(eaddr[0]), .err_seen(eseen[0])
    );

    dmem_bytelane #(
        .ADDR_WIDTH(14), .BASE_ADDR(32'hFFFF0000), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_write(rw[1]), .req_size(rsz[1]), .req_signed(rsg[1]), .req_addr(ra[1]),
        .req_wdata(rwd[1]), .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1]),
        .err_addr(eaddr[1]), .err_seen(eseen[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic drive(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        rv[d]  = 1'b1;
        rw[d]  = wr;
        rsz[d] = sz;
        rsg[d] = sg;
        ra[d]  = addr;
        rwd[d] = wd;
    endtask

    // One request, then wait (bounded) for its response and check it.
    task automatic xact(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rdy[d]), 32'd1);
        drive(d, wr, sz, sg, addr, wd);
        @(negedge clk);
        rv[d] = 1'b0;
        lat = 1;
        while (!vld[d] && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_of(d)));
        chk({tag, "_err"}, 32'(rerr[d]), 32'(exp_err));
        chk({tag, "_data"}, rdat[d], exp_data);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(vld[d]), 32'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [31:0] exp;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
            rv[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_ready_a", 32'(rdy[0]), 32'd0);
        chk("rst_ready_b", 32'(rdy[1]), 32'd1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_valid_%0d", d), 32'(vld[d]), 32'd0);
            chk($sformatf("rst_rdata_%0d", d), rdat[d], 32'd0);
            chk($sformatf("rst_err_%0d", d), 32'(rerr[d]), 32'd0);
            chk($sformatf("rst_seen_%0d", d), 32'(eseen[d]), 32'd0);
            chk($sformatf("rst_eaddr_%0d", d), eaddr[d], 32'd0);
        end

        // Clear walk: 16 words, ready in the 17th cycle after release.
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        cyc = 1;
        while (!rdy[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("clear_ready_cycle", 32'(cyc), 32'd17);
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF003C, 32'h0, 32'h00000000, 1'b0, "clr_lw_top");

        // Byte lanes
        xact(0, 1'b1, SZ_W, 1'b0, 32'hFFFF0000, 32'h11223344, 32'h0, 1'b0, "sw0");
        xact(0, 1'b1, SZ_B, 1'b0, 32'hFFFF0001, 32'h000000AA, 32'h0, 1'b0, "sb1");
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0000, 32'h0, 32'h11AA3344, 1'b0, "lw0");
        xact(0, 1'b0, SZ_B, 1'b1, 32'hFFFF0001, 32'h0, 32'hFFFFFFAA, 1'b0, "lb1");
        xact(0, 1'b0, SZ_B, 1'b0, 32'hFFFF0001, 32'h0, 32'h000000AA, 1'b0, "lbu1");
        xact(0, 1'b0, SZ_B, 1'b1, 32'hFFFF0000, 32'h0, 32'h00000011, 1'b0, "lb0");
        xact(0, 1'b0, SZ_B, 1'b0, 32'hFFFF0003, 32'h0, 32'h00000044, 1'b0, "lbu3");

        // Half lanes
        xact(0, 1'b1, SZ_W, 1'b0, 32'hFFFF0004, 32'h00000000, 32'h0, 1'b0, "sw4");
        xact(0, 1'b1, SZ_H, 1'b0, 32'hFFFF0006, 32'hFFFF8001, 32'h0, 1'b0, "sh6");
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0004, 32'h0, 32'h00008001, 1'b0, "lw4");
        xact(0, 1'b0, SZ_H, 1'b1, 32'hFFFF0006, 32'h0, 32'hFFFF8001, 1'b0, "lh6");
        xact(0, 1'b0, SZ_H, 1'b0, 32'hFFFF0006, 32'h0, 32'h00008001, 1'b0, "lhu6");
        xact(0, 1'b0, SZ_H, 1'b1, 32'hFFFF0004, 32'h0, 32'h00000000, 1'b0, "lh4");

        // Errors: first one is captured, later ones leave err_addr alone
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0002, 32'h0, 32'h0, 1'b1, "err_lw_mis");
        chk("err_seen_first", 32'(eseen[0]), 32'd1);
        chk("err_addr_first", eaddr[0], 32'hFFFF0002);
        xact(0, 1'b1, SZ_H, 1'b0, 32'hFFFF0003, 32'h0000BEEF, 32'h0, 1'b1, "err_sh_mis");
        xact(0, 1'b0, SZ_W, 1'b0, 32'h00001000, 32'h0, 32'h0, 1'b1, "err_lw_low");
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0040, 32'h0, 32'h0, 1'b1, "err_lw_past");
        xact(0, 1'b1, SZ_X, 1'b0, 32'hFFFF0004, 32'hFFFFFFFF, 32'h0, 1'b1, "err_sz11");
        chk("err_addr_sticky", eaddr[0], 32'hFFFF0002);
        chk("err_seen_sticky", 32'(eseen[0]), 32'd1);
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0000, 32'h0, 32'h11AA3344, 1'b0, "err_nochg0");
        xact(0, 1'b0, SZ_W, 1'b0, 32'hFFFF0004, 32'h0, 32'h00008001, 1'b0, "err_nochg4");

        // Latency 3, store at T then load at T+1 on the top word
        @(negedge clk);
        drive(1, 1'b1, SZ_W, 1'b0, 32'hFFFFFFFC, 32'hDEADBEEF);
        exp_q.push_back(32'h00000000);
        @(negedge clk);
        chk("fwd_k1_valid", 32'(vld[1]), 32'd0);
        drive(1, 1'b0, SZ_W, 1'b0, 32'hFFFFFFFC, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("fwd_k2_valid", 32'(vld[1]), 32'd0);
        rv[1] = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk($sformatf("fwd_k%0d_valid", k), 32'(vld[1]), 32'd1);
                chk($sformatf("fwd_k%0d_err", k), 32'(rerr[1]), 32'd0);
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                chk($sformatf("fwd_k%0d_data", k), rdat[1], exp);
            end else begin
                chk($sformatf("fwd_k%0d_valid", k), 32'(vld[1]), 32'd0);
            end
        end
        xact(1, 1'b0, SZ_W, 1'b0, 32'hFFFFFFFC, 32'h0, 32'hDEADBEEF, 1'b0, "top_lw");
        xact(1, 1'b0, SZ_W, 1'b0, 32'hFFFEFFFC, 32'h0, 32'h0, 1'b1, "below_base");
        chk("below_base_eaddr", eaddr[1], 32'hFFFEFFFC);
        xact(1, 1'b1, SZ_W, 1'b0, 32'hFFFF0010, 32'hCAFEF00D, 32'h0, 1'b0, "sw10");

        // Reset with a load in flight: response must vanish, data must survive
        @(negedge clk);
        drive(1, 1'b0, SZ_W, 1'b0, 32'hFFFF0010, 32'h0);
        @(negedge clk);
        rv[1] = 1'b0;
        rst_n[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) rst_n[1] = 1'b1;
            if (vld[1]) seen++;
            @(negedge clk);
        end
        chk("rst_no_resp", 32'(seen), 32'd0);
        chk("rst_seen_clr", 32'(eseen[1]), 32'd0);
        chk("rst_eaddr_clr", eaddr[1], 32'd0);
        xact(1, 1'b0, SZ_W, 1'b0, 32'hFFFF0010, 32'h0, 32'hCAFEF00D, 1'b0, "rst_keep");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
